// File: rtl/pipe_stage.sv
// Elastic pipeline register: one WIDTH-bit stage with valid/ready on both
// sides, a main register plus a one-word skid register so InReady can be a
// plain register output, a synchronous Flush for branch squash, and a
// saturating stall counter for performance debug.
module pipe_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InData,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutData,
    input  logic             Flush,
    output logic [1:0]       Count,
    output logic [CNT_W-1:0] StallCount
);

    // Occupancy encoding doubles as the Count output: {FULL, ONE}.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_FULL  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_accept;
    logic w_out_hs;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid_in;

    // InReady depends only on registered state and reset, never on OutReady
    // or InValid, so long chains of stages do not build combinational paths.
    assign InReady    = (r_state != S_FULL) & Rst;
    assign OutValid   = (r_state != S_EMPTY);
    assign OutData    = r_main_data;
    assign Count      = {r_state == S_FULL, r_state == S_ONE};
    assign StallCount = r_stall_cnt;

    assign w_accept = InValid & InReady;
    assign w_out_hs = OutValid & OutReady;

    // Next occupancy and register-load selects; Flush overrides everything.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid_in   = 1'b0;

        if (Flush) begin
            // Any same-cycle accept is dropped; a same-cycle output
            // handshake has already been taken by downstream.
            w_state_nxt = S_EMPTY;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = S_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_out_hs) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt    = S_FULL;
                        w_load_skid_in = 1'b1;
                    end else if (w_out_hs) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    // InReady is low here, so only the drain case exists.
                    if (w_out_hs) begin
                        w_state_nxt      = S_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // Occupancy state and the head-of-stage data register.
    always_ff @(posedge Clk or negedge Rst) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!Rst) begin
            r_state     <= S_EMPTY;
            r_main_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main_in) begin
                r_main_data <= InData;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
            end
        end
    end

    // Skid data register, only meaningful while the stage is FULL.
    always_ff @(posedge Clk) begin
        // NOTE: no reset on this data-only register; its contents are never
        // observed unless the state says the skid slot holds a word.
        if (w_load_skid_in) begin
            r_skid_data <= InData;
        end
    end

    // Saturating count of cycles where downstream stalls a valid word.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_stall_cnt <= '0;
        end else if (OutValid && !OutReady && (r_stall_cnt != STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage. Instance A (WIDTH=8, CNT_W=3) gets the
// directed scenarios and a randomised run; instance B (WIDTH=64, CNT_W=16)
// gets a randomised run in parallel. Each instance has a queue-based
// scoreboard that tracks occupancy, order, flush drops and stall cycles.
module tb_pipe_stage;

    localparam int A_W  = 8;
    localparam int A_CW = 3;
    localparam int B_W  = 64;
    localparam int B_CW = 16;
    localparam int N_WORDS    = 10000;
    localparam int CYC_BUDGET = 60000;

    logic clk;

    logic              a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [A_W-1:0]    a_in_data, a_out_data;
    logic [1:0]        a_count;
    logic [A_CW-1:0]   a_stall;

    logic              b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [B_W-1:0]    b_in_data, b_out_data;
    logic [1:0]        b_count;
    logic [B_CW-1:0]   b_stall;

    int n_cmp = 0;
    int n_err = 0;

    logic [A_W-1:0] q_a[$];
    logic [B_W-1:0] q_b[$];
    int stall_a = 0;
    int stall_b = 0;
    int acc_a = 0;
    int acc_b = 0;

    pipe_stage #(.WIDTH(A_W), .CNT_W(A_CW)) u_dut_a (
        .Clk(clk), .Rst(a_rst),
        .InValid(a_in_valid), .InReady(a_in_ready), .InData(a_in_data),
        .OutValid(a_out_valid), .OutReady(a_out_ready), .OutData(a_out_data),
        .Flush(a_flush), .Count(a_count), .StallCount(a_stall)
    );

    pipe_stage #(.WIDTH(B_W), .CNT_W(B_CW)) u_dut_b (
        .Clk(clk), .Rst(b_rst),
        .InValid(b_in_valid), .InReady(b_in_ready), .InData(b_in_data),
        .OutValid(b_out_valid), .OutReady(b_out_ready), .OutData(b_out_data),
        .Flush(b_flush), .Count(b_count), .StallCount(b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard A: state is compared mid-cycle, then the upcoming edge's
    // handshakes are applied to the model (pop, then flush or push).
    always @(negedge clk) begin
        logic [A_W-1:0] exp_a;
        if (!a_rst) begin
            q_a.delete();
            stall_a = 0;
        end else begin
            check("a_count", 64'(a_count), 64'(q_a.size()));
            check("a_out_valid", 64'(a_out_valid), 64'(q_a.size() != 0));
            check("a_in_ready", 64'(a_in_ready), 64'(q_a.size() < 2));
            check("a_stall", 64'(a_stall), 64'(stall_a));
            if (a_out_valid && !a_out_ready && stall_a < (1 << A_CW) - 1) stall_a++;
            if (a_out_valid && a_out_ready && q_a.size() != 0) begin
                exp_a = q_a.pop_front();
                check("a_data", 64'(a_out_data), 64'(exp_a));
            end
            if (a_flush) begin
                q_a.delete();
            end else if (a_in_valid && a_in_ready) begin
                q_a.push_back(a_in_data);
                acc_a++;
            end
        end
    end

    // Scoreboard B: same model for the wide instance.
    always @(negedge clk) begin
        logic [B_W-1:0] exp_b;
        if (!b_rst) begin
            q_b.delete();
            stall_b = 0;
        end else begin
            check("b_count", 64'(b_count), 64'(q_b.size()));
            check("b_out_valid", 64'(b_out_valid), 64'(q_b.size() != 0));
            check("b_in_ready", 64'(b_in_ready), 64'(q_b.size() < 2));
            check("b_stall", 64'(b_stall), 64'(stall_b));
            if (b_out_valid && !b_out_ready && stall_b < (1 << B_CW) - 1) stall_b++;
            if (b_out_valid && b_out_ready && q_b.size() != 0) begin
                exp_b = q_b.pop_front();
                check("b_data", b_out_data, exp_b);
            end
            if (b_flush) begin
                q_b.delete();
            end else if (b_in_valid && b_in_ready) begin
                q_b.push_back(b_in_data);
                acc_b++;
            end
        end
    end

    initial begin
        a_rst = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_flush = 1'b0;
        b_rst = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;

        fork
            // ---------------- instance A: directed, then random -------------
            begin
                logic ir;
                int   cyc;
                repeat (3) step();
                check("rst_out_valid", 64'(a_out_valid), 64'(0));
                check("rst_in_ready", 64'(a_in_ready), 64'(0));
                check("rst_count", 64'(a_count), 64'(0));
                check("rst_stall", 64'(a_stall), 64'(0));
                check("rst_out_data", 64'(a_out_data), 64'(0));
                a_rst = 1'b1;
                #1;
                check("release_in_ready", 64'(a_in_ready), 64'(1));

                // Back-to-back stream with downstream always ready.
                a_out_ready = 1'b1;
                a_in_valid  = 1'b1;
                for (int i = 1; i <= 3; i++) begin
                    a_in_data = A_W'(i);
                    step();
                    check("stream_data", 64'(a_out_data), 64'(i));
                    check("stream_count", 64'(a_count), 64'(1));
                    check("stream_in_ready", 64'(a_in_ready), 64'(1));
                end
                a_in_valid = 1'b0;
                step();
                check("stream_drained", 64'(a_out_valid), 64'(0));

                // Skid fill under backpressure, then drain in order.
                a_in_valid = 1'b1; a_in_data = 8'h0A;
                step();
                a_out_ready = 1'b0; a_in_data = 8'h0B;
                step();
                check("skid_count", 64'(a_count), 64'(2));
                check("skid_in_ready", 64'(a_in_ready), 64'(0));
                check("skid_head", 64'(a_out_data), 64'(8'h0A));
                a_in_data = 8'h0C;
                step();
                check("skid_hold_count", 64'(a_count), 64'(2));
                check("skid_hold_head", 64'(a_out_data), 64'(8'h0A));
                a_out_ready = 1'b1;
                step();
                check("skid_drain_b", 64'(a_out_data), 64'(8'h0B));
                check("skid_drain_ready", 64'(a_in_ready), 64'(1));
                step();
                check("skid_drain_c", 64'(a_out_data), 64'(8'h0C));
                a_in_valid = 1'b0;
                step();
                check("skid_empty", 64'(a_out_valid), 64'(0));

                // Flush collides with an output handshake while FULL.
                a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h10;
                step();
                a_in_data = 8'h11;
                step();
                check("flush_pre_count", 64'(a_count), 64'(2));
                a_in_data = 8'h12; a_flush = 1'b1; a_out_ready = 1'b1;
                step();
                a_flush = 1'b0; a_in_valid = 1'b0;
                check("flush_count", 64'(a_count), 64'(0));
                check("flush_out_valid", 64'(a_out_valid), 64'(0));
                check("flush_data_hold", 64'(a_out_data), 64'(8'h10));
                repeat (2) step();
                check("flush_no_ghost", 64'(a_out_valid), 64'(0));

                // Flush drops a same-cycle accept while ONE.
                a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h20;
                step();
                a_in_data = 8'h21; a_flush = 1'b1;
                step();
                a_flush = 1'b0; a_in_valid = 1'b0;
                check("flush1_count", 64'(a_count), 64'(0));
                check("flush1_data_hold", 64'(a_out_data), 64'(8'h20));

                // Stall counter saturation at 2^3-1, immune to Flush.
                a_rst = 1'b0;
                step();
                a_rst = 1'b1;
                check("sat_cleared", 64'(a_stall), 64'(0));
                a_in_valid = 1'b1; a_in_data = 8'h55;
                step();
                a_in_valid = 1'b0;
                for (int i = 1; i <= 10; i++) begin
                    step();
                    check("sat_stall", 64'(a_stall), 64'((i < 7) ? i : 7));
                end
                a_flush = 1'b1;
                step();
                a_flush = 1'b0;
                step();
                check("sat_after_flush", 64'(a_stall), 64'(7));
                check("sat_flush_empty", 64'(a_out_valid), 64'(0));

                // Reset mid-transfer clears everything asynchronously.
                a_in_valid = 1'b1; a_in_data = 8'h66;
                step();
                a_in_valid = 1'b0;
                check("mid_loaded", 64'(a_out_valid), 64'(1));
                a_rst = 1'b0;
                #1;
                check("mid_rst_out_valid", 64'(a_out_valid), 64'(0));
                check("mid_rst_count", 64'(a_count), 64'(0));
                check("mid_rst_in_ready", 64'(a_in_ready), 64'(0));
                check("mid_rst_stall", 64'(a_stall), 64'(0));
                check("mid_rst_data", 64'(a_out_data), 64'(0));
                repeat (2) step();
                a_rst = 1'b1;
                step();

                // Randomised traffic with occasional OutReady toggles mid-cycle.
                cyc = 0;
                acc_a = 0;
                while (acc_a < N_WORDS && cyc < CYC_BUDGET) begin
                    step();
                    a_in_valid  = ($urandom_range(0, 3) != 0);
                    a_in_data   = A_W'($urandom);
                    a_out_ready = ($urandom_range(0, 2) != 0);
                    a_flush     = ($urandom_range(0, 63) == 0);
                    if ($urandom_range(0, 15) == 0) begin
                        ir = a_in_ready;
                        #1 a_out_ready = ~a_out_ready;
                        #1 check("a_ready_no_bypass", 64'(a_in_ready), 64'(ir));
                        a_out_ready = ~a_out_ready;
                    end
                    cyc++;
                end
                check("a_words_done", 64'(acc_a >= N_WORDS), 64'(1));
                a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
                repeat (4) step();
                @(negedge clk);
                #1;
                check("a_drained", 64'(q_a.size()), 64'(0));
            end

            // ---------------- instance B: random, WIDTH=64 ------------------
            begin
                logic ir;
                int   cyc;
                repeat (3) step();
                b_rst = 1'b1;
                cyc = 0;
                while (acc_b < N_WORDS && cyc < CYC_BUDGET) begin
                    step();
                    b_in_valid  = ($urandom_range(0, 3) != 0);
                    b_in_data   = {$urandom, $urandom};
                    b_out_ready = ($urandom_range(0, 2) != 0);
                    b_flush     = ($urandom_range(0, 63) == 0);
                    if ($urandom_range(0, 15) == 0) begin
                        ir = b_in_ready;
                        #1 b_out_ready = ~b_out_ready;
                        #1 check("b_ready_no_bypass", 64'(b_in_ready), 64'(ir));
                        b_out_ready = ~b_out_ready;
                    end
                    cyc++;
                end
                check("b_words_done", 64'(acc_b >= N_WORDS), 64'(1));
                b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
                repeat (4) step();
                @(negedge clk);
                #1;
                check("b_drained", 64'(q_b.size()), 64'(0));
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
